rs232_frame_reader: RTL and testbench

Parametrised successor to the fixed 4-byte RS232 coordinate wrapper. Acts as an Avalon-MM master that polls the RS232 UART core's status register and reads RX bytes. It hunts for a sync byte, then assembles BYTES_PER_WORD payload bytes MSB-first into one word. Completed words are buffered in a FIFO and delivered to game logic over a valid/ready handshake. It adds inter-byte timeout resync, overflow reporting and an error counter.

---
 rtl/rs232_pkg.sv | 19 +
 rtl/rs232_word_fifo.sv | 48 ++++
 rtl/rs232_frame_reader.sv | 159 +++++++++++++++
 tb/tb_rs232_frame_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared constants and state encodings for the RS232 frame reader.
package rs232_pkg;
    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] STATUS_BASE = 5'd8;
    localparam int         RX_OK_BIT   = 7;
    localparam int         TX_OK_BIT   = 6;
    localparam int         ERR_CNT_W   = 8;

    typedef enum logic {
        S_STATUS,
        S_RX
    } link_state_t;

    typedef enum logic [1:0] {
        F_HUNT,
        F_PAYLOAD,
        F_CSUM
    } frame_state_t;
endpackage

// File: rtl/rs232_word_fifo.sv
// Word FIFO with occupancy count; the head is read straight from the storage flops,
// so it is valid the cycle after a push into an empty FIFO.
module rs232_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_idx] <= data;
                wr_idx      <= wr_idx + 1'b1;
            end
            if (do_pop) rd_idx <= rd_idx + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/rs232_frame_reader.sv
// Polls the RS232 UART over Avalon-MM, frames sync-prefixed payloads into words and buffers them.
// Optional trailing XOR checksum byte is enabled by defining RS232_FRAME_CHECKSUM_EN.
//
// state     | meaning
// S_STATUS  | reading status register, waiting for RX_OK
// S_RX      | reading one byte from the RX data register
// F_HUNT    | discarding bytes until SYNC_BYTE
// F_PAYLOAD | shifting payload bytes in, MSB first
// F_CSUM    | waiting for the XOR checksum byte
module rs232_frame_reader
    import rs232_pkg::*;
#(
    parameter int          BYTES_PER_WORD = 4,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50000,
    localparam int         WORD_W         = 8 * BYTES_PER_WORD
) (
    input  logic              avm_clk,
    input  logic              avm_rst_n,
    output logic [4:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [WORD_W-1:0] o_word,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overflow,
    output logic [7:0]        o_err_cnt
);
`ifdef RS232_FRAME_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W = 4;

    link_state_t          link_q, link_d;
    frame_state_t         frame_q, frame_d;
    logic                 xfer, byte_valid;
    logic [7:0]           rx_byte;
    logic [WORD_W-1:0]    shift_q, word_in, push_word;
    logic [CNT_W-1:0]     cnt_q;
    logic [7:0]           csum_q;
    logic [TMR_W-1:0]     tmr_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 ovf_q;
    logic                 last_byte, timeout_hit, word_done, err_event;
    logic                 fifo_full, fifo_empty, pop;
    logic                 unused_readdata;

    assign xfer            = avm_read && !avm_waitrequest;
    assign byte_valid      = xfer && (link_q == S_RX);
    assign rx_byte         = avm_readdata[7:0];
    assign unused_readdata = ^avm_readdata[31:8];
    assign avm_address     = (link_q == S_RX) ? RX_BASE : STATUS_BASE;

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            link_q   <= S_STATUS;
            avm_read <= 1'b0;
        end else begin
            link_q   <= link_d;
            avm_read <= 1'b1;
        end
    end

    always_comb begin
        link_d = link_q;
        case (link_q)
            S_STATUS: if (xfer && avm_readdata[RX_OK_BIT]) link_d = S_RX;
            S_RX:     if (xfer) link_d = S_STATUS;
            default:  link_d = S_STATUS;
        endcase
    end

    assign last_byte   = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    // A byte landing on the expiry cycle keeps the frame alive.
    assign timeout_hit = (frame_q != F_HUNT) && !byte_valid &&
                         (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign word_in     = (shift_q << 8) | WORD_W'(rx_byte);

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) frame_q <= F_HUNT;
        else            frame_q <= frame_d;
    end

    always_comb begin
        frame_d = frame_q;
        case (frame_q)
            F_HUNT:    if (byte_valid && rx_byte == SYNC_BYTE) frame_d = F_PAYLOAD;
            F_PAYLOAD: begin
                if (byte_valid && last_byte) frame_d = CSUM_EN ? F_CSUM : F_HUNT;
                else if (timeout_hit)        frame_d = F_HUNT;
            end
            F_CSUM:    if (byte_valid || timeout_hit) frame_d = F_HUNT;
            default:   frame_d = F_HUNT;
        endcase
    end

    always_comb begin
        word_done = 1'b0;
        err_event = timeout_hit;
        push_word = word_in;
        if (frame_q == F_PAYLOAD) begin
            word_done = byte_valid && last_byte && !CSUM_EN;
        end else if (frame_q == F_CSUM && byte_valid) begin
            push_word = shift_q;
            word_done = (rx_byte == csum_q);
            err_event = (rx_byte != csum_q);
        end
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            tmr_q   <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= word_done && fifo_full && !pop;
            if (err_event && err_q != '1) err_q <= err_q + 1'b1;
            if (frame_q == F_HUNT || byte_valid || timeout_hit) tmr_q <= '0;
            else                                                tmr_q <= tmr_q + 1'b1;
            if (byte_valid && frame_q == F_HUNT) begin
                shift_q <= '0;
                cnt_q   <= '0;
                csum_q  <= '0;
            end else if (byte_valid && frame_q == F_PAYLOAD) begin
                shift_q <= word_in;
                cnt_q   <= cnt_q + 1'b1;
                csum_q  <= csum_q ^ rx_byte;
            end
        end
    end

    assign pop = i_ready && !fifo_empty;

    rs232_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (avm_clk),
        .rst_n (avm_rst_n),
        .push  (word_done),
        .data  (push_word),
        .pop   (pop),
        .head  (o_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_valid    = !fifo_empty;
    assign o_overflow = ovf_q;
    assign o_err_cnt  = err_q;
endmodule

// File: tb/tb_rs232_frame_reader.sv
// Directed bench: behavioural UART slave fed from a byte queue, word capture at the consumer side.
module tb_rs232_frame_reader;
`ifdef RS232_FRAME_CHECKSUM_EN
    localparam int BPW = 2;
`else
    localparam int BPW = 4;
`endif
    localparam int W = 8 * BPW;

    logic         avm_clk;
    logic         avm_rst_n;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_waitrequest;
    logic [W-1:0] o_word;
    logic         o_valid;
    logic         i_ready;
    logic         o_overflow;
    logic [7:0]   o_err_cnt;

    int           n_tests;
    int           n_fail;
    int           ovf_cnt;
    int           stall_left;
    logic [7:0]   rx_q[$];
    logic [W-1:0] got_q[$];

    rs232_frame_reader #(
        .BYTES_PER_WORD (BPW),
        .FIFO_DEPTH     (4),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (50000)
    ) dut (
        .avm_clk         (avm_clk),
        .avm_rst_n       (avm_rst_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .o_word          (o_word),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_overflow      (o_overflow),
        .o_err_cnt       (o_err_cnt)
    );

    initial avm_clk = 1'b0;
    always #5 avm_clk = ~avm_clk;

    // One clock: slave answers at the negedge, bookkeeping #1 after the posedge.
    task automatic step();
        logic [4:0] addr_s;
        logic       rd_s;
        logic       stall_s;
        @(negedge avm_clk);
        if (o_overflow) ovf_cnt++;
        if (o_valid && i_ready) got_q.push_back(o_word);
        addr_s  = avm_address;
        rd_s    = avm_read;
        stall_s = (stall_left > 0);
        avm_waitrequest = stall_s;
        if (addr_s == 5'd8) avm_readdata = {24'd0, rx_q.size() > 0, 7'd0};
        else                avm_readdata = (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'd0;
        @(posedge avm_clk);
        #1;
        if (rd_s && stall_s) stall_left--;
        else if (rd_s && avm_rst_n && addr_s == 5'd0 && rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic push_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
    endtask

    task automatic run_until_empty(input string tag);
        int n = 0;
        while (rx_q.size() > 0 && n < 2000) begin
            step();
            n++;
        end
        n_tests++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bytes still queued, required 0", tag, rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_reset();
        avm_rst_n = 1'b0;
        repeat (3) step();
        n_tests++; if (avm_address !== 5'd8) begin n_fail++; $display("FAIL rst_address: got %0d want 8", avm_address); end
        n_tests++; if (avm_read !== 1'b0)    begin n_fail++; $display("FAIL rst_read: got %b want 0", avm_read); end
        n_tests++; if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_tests++; if (o_word !== '0)        begin n_fail++; $display("FAIL rst_word: got %h want 0", o_word); end
        n_tests++; if (o_overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_overflow: got %b want 0", o_overflow); end
        n_tests++; if (o_err_cnt !== 8'd0)   begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", o_err_cnt); end
        avm_rst_n = 1'b1;
        step();
        n_tests++; if (avm_read !== 1'b1)    begin n_fail++; $display("FAIL read_after_rst: got %b want 1", avm_read); end
    endtask

`ifndef RS232_FRAME_CHECKSUM_EN
    task automatic test_basic();
        logic pre_v;
        int   n;
        pre_v = 1'b1;
        n = 0;
        repeat (10) step();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", o_valid); end
        push_bytes(64'hA5_12345678, 5);
        stall_left = 3;
        while (rx_q.size() > 0 && n < 200) begin
            if (rx_q.size() == 1) pre_v = o_valid;
            step();
            n++;
        end
        n_tests++; if (pre_v !== 1'b0)   begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", pre_v); end
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got valid %b want 1", o_valid); end
        n_tests++; if (o_word !== 32'h12345678) begin n_fail++; $display("FAIL basic_word: got %h want 12345678", o_word); end
        i_ready = 1'b1;
        repeat (5) step();
        i_ready = 1'b0;
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 32'h12345678) begin
            n_fail++; $display("FAIL basic_count: got %0d words want 1 word 12345678", got_q.size());
        end
    endtask

    task automatic test_garbage_sync();
        got_q.delete();
        push_bytes(64'h00FFA5A5010203, 7);
        run_until_empty("garbage");
        step();
        i_ready = 1'b1;
        repeat (4) step();
        i_ready = 1'b0;
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 32'hA5010203) begin
            n_fail++; $display("FAIL garbage_word: got %0d words (first %h) want 1 word a5010203",
                               got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
        end
    endtask

    task automatic test_timeout();
        got_q.delete();
        push_bytes(64'hA51122, 3);
        run_until_empty("timeout_partial");
        repeat (60000) step();
        n_tests++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", o_err_cnt); end
        n_tests++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL timeout_valid: got %b want 0", o_valid); end
        push_bytes(64'hA5_01020304, 5);
        run_until_empty("timeout_frame");
        step();
        i_ready = 1'b1;
        repeat (4) step();
        i_ready = 1'b0;
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 32'h01020304) begin
            n_fail++; $display("FAIL timeout_word: got %0d words want 1 word 01020304", got_q.size());
        end
        n_tests++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_err_hold: got %0d want 1", o_err_cnt); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        got_q.delete();
        ovf_cnt = 0;
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_bytes({24'd0, 8'hA5, 32'h11121314 + 32'h10101010 * k}, 5);
        run_until_empty("overflow");
        repeat (3) step();
        n_tests++; if (ovf_cnt != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt); end
        n_tests++; if (o_word !== 32'h11121314) begin n_fail++; $display("FAIL ovf_head: got %h want 11121314", o_word); end
        i_ready = 1'b1;
        repeat (8) step();
        i_ready = 1'b0;
        n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            exp_w = 32'h11121314 + 32'h10101010 * i;
            n_tests++;
            if (got_q[i] !== exp_w) begin n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], exp_w); end
        end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        push_bytes(64'hA5_C0C1C2C3_A511, 7);
        run_until_empty("rst_mid");
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", o_valid); end
        avm_rst_n = 1'b0;
        step();
        n_tests++; if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
        n_tests++; if (o_word !== '0)       begin n_fail++; $display("FAIL rstmid_word: got %h want 0", o_word); end
        n_tests++; if (o_err_cnt !== 8'd0)  begin n_fail++; $display("FAIL rstmid_err: got %0d want 0", o_err_cnt); end
        n_tests++; if (avm_read !== 1'b0)   begin n_fail++; $display("FAIL rstmid_read: got %b want 0", avm_read); end
        avm_rst_n = 1'b1;
        step();
        push_bytes(64'hA5_AABBCCDD, 5);
        run_until_empty("rst_after");
        step();
        i_ready = 1'b1;
        repeat (4) step();
        i_ready = 1'b0;
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 32'hAABBCCDD) begin
            n_fail++; $display("FAIL rstmid_word_after: got %0d words want 1 word aabbccdd", got_q.size());
        end
    endtask
`else
    task automatic test_checksum();
        got_q.delete();
        ovf_cnt = 0;
        push_bytes(64'hA5_0FF0_FF, 4);
        run_until_empty("csum_good");
        step();
        i_ready = 1'b1;
        repeat (4) step();
        i_ready = 1'b0;
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 16'h0FF0) begin
            n_fail++; $display("FAIL csum_good_word: got %0d words want 1 word 0ff0", got_q.size());
        end
        n_tests++; if (o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL csum_good_err: got %0d want 0", o_err_cnt); end
        got_q.delete();
        push_bytes(64'hA5_0FF0_00, 4);
        run_until_empty("csum_bad");
        step();
        i_ready = 1'b1;
        repeat (4) step();
        i_ready = 1'b0;
        n_tests++; if (got_q.size() != 0)  begin n_fail++; $display("FAIL csum_bad_word: got %0d words want 0", got_q.size()); end
        n_tests++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL csum_bad_err: got %0d want 1", o_err_cnt); end
        push_bytes(64'hA5_1234_26, 4);
        run_until_empty("csum_third");
        step();
        i_ready = 1'b1;
        repeat (4) step();
        i_ready = 1'b0;
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 16'h1234) begin
            n_fail++; $display("FAIL csum_third_word: got %0d words want 1 word 1234", got_q.size());
        end
        n_tests++; if (ovf_cnt != 0) begin n_fail++; $display("FAIL csum_ovf: got %0d want 0", ovf_cnt); end
    endtask
`endif

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        ovf_cnt         = 0;
        stall_left      = 0;
        avm_rst_n       = 1'b0;
        avm_readdata    = 32'd0;
        avm_waitrequest = 1'b0;
        i_ready         = 1'b0;
        test_reset();
`ifndef RS232_FRAME_CHECKSUM_EN
        test_basic();
        test_garbage_sync();
        test_timeout();
        test_overflow();
        test_reset_mid();
`else
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
